// File: rtl/grid_walker.sv
// rtl/grid_walker.sv - command-queued grid walker with a two-state move executor
// Edge behaviour: GRID_WALKER_WRAP_EN defined wraps coordinates, undefined saturates them.
module grid_walker #(
  parameter int W     = 4,
  parameter int SW    = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_dir,
  input  logic [SW-1:0]            cmd_step,
  output logic                     cmd_ready,
  output logic [W-1:0]             x,
  output logic [W-1:0]             y,
  output logic [2*W-1:0]           led,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   qcount
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, MOVE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [SW-1:0]       rem_q, rem_d;
  logic [W-1:0]        x_q, x_d, y_q, y_d;
  logic                done_q, done_d;
  logic [AW:0]         count_q, count_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SW+1:0]       fifo_q [DEPTH];
  logic [SW+1:0]       head;
  logic                push, pop;

  function automatic logic [W-1:0] step_up(input logic [W-1:0] v);
`ifdef GRID_WALKER_WRAP_EN
    step_up = v + W'(1);
`else
    step_up = (v == {W{1'b1}}) ? v : v + W'(1);
`endif
  endfunction

  function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
`ifdef GRID_WALKER_WRAP_EN
    step_down = v - W'(1);
`else
    step_down = (v == '0) ? v : v - W'(1);
`endif
  endfunction

  assign cmd_ready = (count_q != (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          dir_d = head[SW+1:SW];
          rem_d = head[SW-1:0];
          if (head[SW-1:0] != '0) state_d = MOVE;
          else                    done_d  = 1'b1;
        end
      end
      MOVE: begin
        // Blocked moves at a saturated edge still burn a cycle so done timing is mode-independent.
        case (dir_q)
          2'b00:   x_d = step_up(x_q);
          2'b01:   x_d = step_down(x_q);
          2'b10:   y_d = step_up(y_q);
          default: y_d = step_down(y_q);
        endcase
        rem_d = rem_q - SW'(1);
        if (rem_q == SW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= 2'b00;
      rem_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      x_q      <= x_d;
      y_q      <= y_d;
      done_q   <= done_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= {cmd_dir, cmd_step};
  end

  assign x      = x_q;
  assign y      = y_q;
  assign led    = {y_q, x_q};
  assign busy   = (state_q == MOVE) || (count_q != '0);
  assign done   = done_q;
  assign qcount = count_q;

endmodule

// File: tb/tb_grid_walker.sv
// tb/tb_grid_walker.sv - scoreboard bench for grid_walker
module tb_grid_walker;
  localparam int W = 4, SW = 2, DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [1:0]     cmd_dir = 2'b00;
  logic [SW-1:0]  cmd_step = '0;
  logic           cmd_ready, busy, done;
  logic [W-1:0]   x, y;
  logic [2*W-1:0] led;
  logic [2:0]     qcount;

  grid_walker #(.W(W), .SW(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_step(cmd_step), .cmd_ready(cmd_ready), .x(x), .y(y), .led(led),
    .busy(busy), .done(done), .qcount(qcount)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0, done_cnt = 0;
  logic [2*W-1:0] exp_q[$];
  int done_cyc[$];
  logic [W-1:0] mx = '0, my = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every done pulse retires the oldest accepted command; compare final position.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [2*W-1:0] e;
      done_cnt++;
      done_cyc.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected got done=1 with no command pending, want none");
      end else begin
        e = exp_q.pop_front();
        if ({y, x} !== e) begin
          fails++;
          $display("FAIL done_position got {y,x}=%h want %h", {y, x}, e);
        end
      end
    end
  end

  function automatic void model(input logic [1:0] d, input logic [SW-1:0] s);
    for (int i = 0; i < int'(s); i++) begin
`ifdef GRID_WALKER_WRAP_EN
      case (d)
        2'b00: mx = mx + 1'b1;
        2'b01: mx = mx - 1'b1;
        2'b10: my = my + 1'b1;
        default: my = my - 1'b1;
      endcase
`else
      case (d)
        2'b00: if (mx != 4'hF) mx = mx + 1'b1;
        2'b01: if (mx != 4'h0) mx = mx - 1'b1;
        2'b10: if (my != 4'hF) my = my + 1'b1;
        default: if (my != 4'h0) my = my - 1'b1;
      endcase
`endif
    end
    exp_q.push_back({my, mx});
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cmd_valid = 1'b0;
    tick;
    reset = 1'b0;
    mx = '0;
    my = '0;
    exp_q.delete();
  endtask

  task automatic send(input logic [1:0] d, input logic [SW-1:0] s);
    bit ok = 0;
    cmd_dir = d;
    cmd_step = s;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin
        model(d, s);
        tick;
        ok = 1;
        break;
      end
      tick;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout got cmd_ready=0 for 100 cycles, want 1");
    end
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      tick;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout got busy=1 after 300 cycles, want 0");
    end
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir = 2'b00;
    cmd_step = 2'd3;
    tick;
    reset = 1'b0;
    cmd_valid = 1'b0;
    mx = '0; my = '0; exp_q.delete();
    tests++; if ({y, x} !== 8'h00) begin fails++; $display("FAIL reset_pos got %h want 00", {y, x}); end
    tests++; if (qcount !== 3'd0) begin fails++; $display("FAIL reset_qcount got %0d want 0", qcount); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    tick;
    tests++; if (qcount !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL reset_discard got qcount=%0d busy=%b want 0 0", qcount, busy); end
  endtask

  task automatic test_latency;
    do_reset;
    send(2'b00, 2'd3);
    tests++; if (qcount !== 3'd1 || busy !== 1'b1) begin fails++; $display("FAIL lat_accept got qcount=%0d busy=%b want 1 1", qcount, busy); end
    tick;
    tests++; if (qcount !== 3'd0 || x !== 4'd0) begin fails++; $display("FAIL lat_pop got qcount=%0d x=%0d want 0 0", qcount, x); end
    for (int i = 1; i <= 3; i++) begin
      tick;
      tests++; if (x !== W'(i)) begin fails++; $display("FAIL lat_x%0d got %0d want %0d", i, x, i); end
    end
    tests++; if (done !== 1'b1 || y !== 4'd0 || led !== 8'h03) begin fails++; $display("FAIL lat_done got done=%b y=%0d led=%h want 1 0 03", done, y, led); end
    tick;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL lat_after got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_full;
    int nacc = 0, d0;
    bit saw_full = 0;
    do_reset;
    d0 = done_cnt;
    cmd_dir = 2'b00;
    cmd_step = 2'd3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (qcount == 3'd4) begin
        saw_full = 1;
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", cmd_ready); end
      end
      if (cmd_ready) begin
        model(2'b00, 2'd3);
        nacc++;
      end
      tick;
    end
    cmd_valid = 1'b0;
    tests++; if (saw_full !== 1'b1) begin fails++; $display("FAIL full_reached got qcount max below 4, want 4"); end
    tests++; if (nacc != 5) begin fails++; $display("FAIL full_accepted got %0d want 5", nacc); end
    wait_idle;
    tests++; if (done_cnt - d0 != nacc) begin fails++; $display("FAIL full_dones got %0d want %0d", done_cnt - d0, nacc); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL full_pending got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_edge;
    logic [W-1:0] ex [3];
`ifdef GRID_WALKER_WRAP_EN
    ex[0] = 4'd15; ex[1] = 4'd0; ex[2] = 4'd1;
`else
    ex[0] = 4'd15; ex[1] = 4'd15; ex[2] = 4'd15;
`endif
    do_reset;
    for (int i = 0; i < 4; i++) send(2'b00, 2'd3);
    send(2'b00, 2'd2);
    wait_idle;
    tests++; if (x !== 4'd14) begin fails++; $display("FAIL edge_start got x=%0d want 14", x); end
    send(2'b00, 2'd3);
    tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++; if (x !== ex[i]) begin fails++; $display("FAIL edge_x%0d got %0d want %0d", i, x, ex[i]); end
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL edge_done got %b want 1", done); end
    wait_idle;
  endtask

  task automatic test_zero;
    do_reset;
    send(2'b00, 2'd2);
    wait_idle;
    send(2'b10, 2'd0);
    tests++; if (qcount !== 3'd1) begin fails++; $display("FAIL zero_queued got %0d want 1", qcount); end
    tick;
    tests++; if (done !== 1'b1 || busy !== 1'b0 || qcount !== 3'd0) begin fails++; $display("FAIL zero_pop got done=%b busy=%b qcount=%0d want 1 0 0", done, busy, qcount); end
    tests++; if ({y, x} !== 8'h02) begin fails++; $display("FAIL zero_pos got %h want 02", {y, x}); end
    tick;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zero_after got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_reset_mid;
    int d0;
    do_reset;
    send(2'b10, 2'd3);
    tick;
    tick;
    tests++; if (y !== 4'd1) begin fails++; $display("FAIL mid_first got y=%0d want 1", y); end
    d0 = done_cnt;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    mx = '0; my = '0; exp_q.delete();
    tests++; if (y !== 4'd0 || qcount !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL mid_reset got y=%0d qcount=%0d busy=%b done=%b want 0 0 0 0", y, qcount, busy, done);
    end
    for (int i = 0; i < 5; i++) tick;
    tests++; if (done_cnt != d0 || y !== 4'd0) begin fails++; $display("FAIL mid_nodone got dones=%0d y=%0d want 0 0", done_cnt - d0, y); end
  endtask

  task automatic test_back_to_back;
    int c_acc, nd = 0;
    do_reset;
    done_cyc.delete();
    send(2'b00, 2'd2);
    c_acc = cyc;
    send(2'b10, 2'd1);
    send(2'b01, 2'd1);
    for (int i = 0; i < 30; i++) begin
      tick;
      if (done) begin
        nd++;
        if (nd == 3) begin
          tests++; if ({y, x} !== 8'h11 || busy !== 1'b0) begin fails++; $display("FAIL b2b_final got {y,x}=%h busy=%b want 11 0", {y, x}, busy); end
          break;
        end
      end
    end
    tick;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL b2b_after got busy=%b done=%b want 0 0", busy, done); end
    tests++;
    if (done_cyc.size() != 3) begin
      fails++; $display("FAIL b2b_count got %0d want 3", done_cyc.size());
    end else if (done_cyc[0] - c_acc != 3 || done_cyc[1] - done_cyc[0] != 2 || done_cyc[2] - done_cyc[1] != 2) begin
      fails++; $display("FAIL b2b_spacing got %0d,%0d,%0d want 3,2,2", done_cyc[0] - c_acc, done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_latency;
    test_full;
    test_edge;
    test_zero;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
